// File: rtl/output_reorder_serializer.sv
// output_reorder_serializer: ping-pong frame buffer that stores a parallel frame in bit-reversed
// order and streams it out one sample per beat with valid/ready handshakes on both sides.
package output_reorder_serializer_pkg;
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_product_t;
endpackage

module output_reorder_serializer
    import output_reorder_serializer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  complex_product_t       in_array [N],
    output logic                   out_valid,
    input  logic                   out_ready,
    output complex_product_t       out_data,
    output logic [$clog2(N)-1:0]   out_index,
    output logic                   out_last
);
    localparam int L = $clog2(N);

    complex_product_t mem [2][N];
    logic [1:0]       full;
    logic             wr_sel;
    logic             rd_sel;
    logic [L-1:0]     rd_cnt;
    logic             accept;
    logic             beat;
    logic             drain;

    function automatic logic [L-1:0] bitrev(input logic [L-1:0] k);
        for (int b = 0; b < L; b++) bitrev[b] = k[L-1-b];
    endfunction

    // in_ready depends only on registered flags (and reset), never on either handshake input
    assign in_ready = !reset && !(&full);

    always_comb begin
        out_valid = !reset && full[rd_sel];
        out_data  = out_valid ? mem[rd_sel][rd_cnt] : '0;
        out_index = out_valid ? rd_cnt : '0;
        out_last  = out_valid && (rd_cnt == L'(N - 1));
        accept    = in_valid && in_ready;
        beat      = out_valid && out_ready;
        drain     = beat && out_last;
    end

    always_ff @(posedge clk) begin
        if (accept)
            for (int k = 0; k < N; k++) mem[wr_sel][k] <= in_array[bitrev(L'(k))];
    end

    // accept targets an EMPTY buffer and drain a FULL one, so both may update in the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            rd_cnt <= '0;
        end else begin
            full <= (full | ({1'b0, accept} << wr_sel)) & ~({1'b0, drain} << rd_sel);
            if (accept) wr_sel <= !wr_sel;
            if (beat) rd_cnt <= rd_cnt + 1'b1;
            if (drain) rd_sel <= !rd_sel;
        end
    end
endmodule

// File: doc/output_reorder_serializer.md
OUTPUT_REORDER_SERIALIZER -- requirements
Module: output_reorder_serializer

Interface
REQ-001 Parameter: N, default 8, number of complex samples per frame; power of two, >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  in_array holds a complete frame.
REQ-005 Port: in_ready  output  1  block can accept a frame this cycle.
REQ-006 Port: in_array  input  N x complex_product_t  parallel frame, element i is natural index i.
REQ-007 Port: out_valid  output  1  out_data holds a valid sample.
REQ-008 Port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 Port: out_data  output  complex_product_t  serial output sample.
REQ-010 Port: out_index  output  $clog2(N)  position of out_data within its frame, 0..N-1.
REQ-011 Port: out_last  output  1  out_data is the final sample of the frame (out_index == N-1).

Function
REQ-012 The block SHALL hold two frame buffers (ping-pong), each with a FULL/EMPTY flag, plus a write select, a read select and an element counter rd_cnt.
REQ-013 Frame accept SHALL occur on a posedge where in_valid && in_ready; no other event writes a buffer.
REQ-014 On accept, the write-select buffer SHALL store slot k = in_array[bitrev(k)] for all k, where bitrev reverses the $clog2(N) index bits; that buffer SHALL become FULL and the write select SHALL toggle.
REQ-015 in_ready SHALL be 1 iff at least one buffer is EMPTY, from registered state only; there is no combinational path from out_ready or in_valid to in_ready.
REQ-016 out_valid SHALL be 1 iff the read-select buffer is FULL.
REQ-017 While out_valid, out_data SHALL equal slot rd_cnt of the read-select buffer, out_index SHALL equal rd_cnt, and out_last SHALL equal (rd_cnt == N-1).
REQ-018 While out_valid == 0, out_data, out_index and out_last SHALL be driven 0.
REQ-019 Output beat SHALL occur on a posedge where out_valid && out_ready; rd_cnt SHALL increment by 1 per beat.
REQ-020 On a beat with out_last, rd_cnt SHALL wrap to 0, the read-select buffer SHALL become EMPTY and the read select SHALL toggle.
REQ-021 out_valid, out_data, out_index and out_last SHALL hold stable while out_valid && !out_ready.
REQ-022 Latency: a frame accepted at posedge t into an otherwise empty block SHALL present out_index 0 with out_valid = 1 in the cycle after t.
REQ-023 Throughput: with out_ready held 1 and in_valid held 1, output SHALL be gap-free at one sample per cycle, N cycles per frame.
REQ-024 Simultaneous accept and last beat SHALL both take effect: one buffer is freed, the other written, and flags update consistently in the same edge.
REQ-025 When both buffers are FULL, in_ready SHALL be 0, including in the cycle the last beat drains; in_ready rises the following cycle.
REQ-026 Frames SHALL be emitted in acceptance order; no frame is dropped or duplicated.

Reset
REQ-027 While reset is asserted at a posedge, both buffers SHALL become EMPTY, both selects and rd_cnt SHALL become 0, in_valid SHALL be ignored.
REQ-028 During and after reset: out_valid = 0, out_data = 0, out_index = 0, out_last = 0; in_ready = 0 while reset is high and 1 on the first cycle after reset deasserts.
REQ-029 Reset mid-frame SHALL discard all buffered and partially emitted frames; buffer storage need not be cleared.

Verification
REQ-030 N=8, in_array[i] = {re=i, im=0}, out_ready=1: out_data.re sequence 0,4,2,6,1,5,3,7 in cycles t+1..t+8, out_index 0..7, out_last only on the 8th beat, in_ready stays 1.
REQ-031 out_ready=0, present three frames A,B,C back to back: A and B accepted, in_ready = 0 from the cycle after B, C held; raise out_ready: A then B then C emitted in order with no gap.
REQ-032 Stall mid-frame: drop out_ready at out_index 3 for 4 cycles: out_data, out_index and out_valid hold the index-3 values, resume at 3 with no skipped or repeated index.
REQ-033 One buffer FULL, frame B presented on the cycle A emits out_last: both events occur, out_index 0 of B appears the next cycle, no bubble.
REQ-034 Reset asserted at out_index 5 of a frame with a second frame buffered: next cycle out_valid = 0 and all outputs 0; after release in_ready = 1; a new frame emits from out_index 0 with correct bit-reversed data.
REQ-035 Random in_valid/out_ready stress, 1000 frames, scoreboard compares each emitted frame against the bit-reversed input frame and checks REQ-015/021/025 every cycle.
